// File: rtl/kl_mem_target.sv
// rtl/kl_mem_target.sv - KLink responder backed by a 64-bit synchronous RAM
//
// Accepts one KLink request at a time from the link RX side, services it
// against an internal RAM of 2^MEM_ADDR_WIDTH 64-bit words, and returns the
// response on the link TX side. Reads return one data beat per request beat.
// Writes return a single dataless acknowledge.
//
// Ports:
//   clk, rst            clock (posedge) and synchronous active-high reset
//   kl_rx_addr/data/den/size/id, kl_rx_valid -> kl_rx_ready
//                       request header and write data beats
//   kl_tx_addr/data/den/size/id, kl_tx_valid <- kl_tx_ready
//                       read data beats (den=1) or write ack (den=0)

module kl_mem_target #(
   parameter int MEM_ADDR_WIDTH  = 10,
   parameter int MAX_BURST_WIDTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] kl_rx_addr,
   input  logic [63:0] kl_rx_data,
   input  logic        kl_rx_den,
   input  logic [2:0]  kl_rx_size,
   input  logic [4:0]  kl_rx_id,
   input  logic        kl_rx_valid,
   output logic        kl_rx_ready,
   output logic [31:0] kl_tx_addr,
   output logic [63:0] kl_tx_data,
   output logic        kl_tx_den,
   output logic [2:0]  kl_tx_size,
   output logic [4:0]  kl_tx_id,
   output logic        kl_tx_valid,
   input  logic        kl_tx_ready
);

   localparam int CW    = MAX_BURST_WIDTH + 1;
   localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_DATA,
      S_WR_ACK,
      S_RD_FETCH,
      S_RD_SEND
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic                      init_q;
   logic [31:0]               addr_q;
   logic [2:0]                size_q;
   logic [4:0]                id_q;
   logic [CW-1:0]             last_q;
   logic [CW-1:0]             beat_q;
   logic [CW-1:0]             beat_nxt;
   logic [MEM_ADDR_WIDTH-1:0] base_q;

   logic                      rx_hs;
   logic                      tx_hs;
   logic                      ram_we;
   logic                      ram_re;
   logic [MEM_ADDR_WIDTH-1:0] wr_word;
   logic [MEM_ADDR_WIDTH-1:0] rd_word;
   logic [2:0]                be_size;
   logic [2:0]                be_off;
   logic [7:0]                wr_be;
   logic [63:0]               ram_q;
   logic [63:0]               mem [DEPTH];
   logic                      unused_addr_bits;

   // Index of the last beat (N-1) for a transfer of 2^size bytes; anything
   // up to one word is a single beat, larger sizes clamp at the max burst.
   function automatic logic [CW-1:0] last_index(input logic [2:0] size);
      int e;
      logic [CW-1:0] r;
      e = int'(size) - 3;
      if (e <= 0)
         r = '0;
      else if (e >= MAX_BURST_WIDTH)
         r = CW'((1 << MAX_BURST_WIDTH) - 1);
      else
         r = CW'((1 << e) - 1);
      return r;
   endfunction

   // Upper address bits alias onto the RAM.
   assign unused_addr_bits = ^kl_rx_addr[31:MEM_ADDR_WIDTH+3];

   // Handshake flags come from the state register only; rst forces the
   // outputs quiet, and init_q holds rx_ready low for the cycle after reset.
   assign kl_rx_ready = !rst && ((state == S_IDLE && !init_q) || state == S_WR_DATA);
   assign kl_tx_valid = !rst && (state == S_WR_ACK || state == S_RD_SEND);
   assign rx_hs       = kl_rx_valid && kl_rx_ready;
   assign tx_hs       = kl_tx_valid && kl_tx_ready;

   assign kl_tx_addr  = rst ? '0 : addr_q;
   assign kl_tx_size  = rst ? '0 : size_q;
   assign kl_tx_id    = rst ? '0 : id_q;
   assign kl_tx_den   = !rst && state == S_RD_SEND;
   assign kl_tx_data  = (!rst && state == S_RD_SEND) ? ram_q : '0;

   // Beat 0 of a write lands in IDLE straight from the RX bus, before the
   // base word has been latched.
   assign rd_word = base_q + MEM_ADDR_WIDTH'(beat_q);
   assign wr_word = (state == S_IDLE) ? kl_rx_addr[MEM_ADDR_WIDTH+2:3] : rd_word;

   // Sub-word writes only occur as single-beat requests taken in IDLE;
   // lanes that would run past byte 7 are simply not enabled.
   always_comb begin
      be_size = (state == S_IDLE) ? kl_rx_size : size_q;
      be_off  = (state == S_IDLE) ? kl_rx_addr[2:0] : addr_q[2:0];
      wr_be   = '1;
      if (be_size < 3'd3) begin
         for (int i = 0; i < 8; i++) begin
            wr_be[i] = (i >= int'(be_off)) && (i < int'(be_off) + (1 << int'(be_size)));
         end
      end
   end

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat_q;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_hs) begin
               if (kl_rx_den) begin
                  ram_we    = 1'b1;
                  beat_nxt  = CW'(1);
                  state_nxt = (last_index(kl_rx_size) == '0) ? S_WR_ACK : S_WR_DATA;
               end else begin
                  beat_nxt  = '0;
                  state_nxt = S_RD_FETCH;
               end
            end
         end
         S_WR_DATA: begin
            if (rx_hs) begin
               ram_we = 1'b1;
               if (beat_q == last_q)
                  state_nxt = S_WR_ACK;
               else
                  beat_nxt = beat_q + CW'(1);
            end
         end
         S_WR_ACK: begin
            if (tx_hs)
               state_nxt = S_IDLE;
         end
         S_RD_FETCH: begin
            ram_re    = 1'b1;
            state_nxt = S_RD_SEND;
         end
         S_RD_SEND: begin
            if (tx_hs) begin
               if (beat_q == last_q) begin
                  state_nxt = S_IDLE;
               end else begin
                  beat_nxt  = beat_q + CW'(1);
                  state_nxt = S_RD_FETCH;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         init_q <= 1'b1;
         beat_q <= '0;
         last_q <= '0;
         base_q <= '0;
         addr_q <= '0;
         size_q <= '0;
         id_q   <= '0;
      end else begin
         state  <= state_nxt;
         init_q <= 1'b0;
         beat_q <= beat_nxt;
         if (state == S_IDLE && rx_hs) begin
            addr_q <= kl_rx_addr;
            size_q <= kl_rx_size;
            id_q   <= kl_rx_id;
            last_q <= last_index(kl_rx_size);
            base_q <= kl_rx_addr[MEM_ADDR_WIDTH+2:3];
         end
      end
   end

   // RAM contents and read register are deliberately not reset. ram_q only
   // changes in RD_FETCH, so it stays stable while a beat waits in RD_SEND.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 8; i++) begin
            if (wr_be[i])
               mem[wr_word][i*8 +: 8] <= kl_rx_data[i*8 +: 8];
         end
      end
      if (ram_re)
         ram_q <= mem[rd_word];
   end

endmodule

// File: doc/kl_mem_target.md
# kl_mem_target

KLink responder with a self-contained 64-bit-wide synchronous RAM, the far-end counterpart of the KLink initiator logic. Consumes request streams from the RX side of an MLink transceiver (reads: dataless request; writes: request carrying data beats) and returns responses on the transceiver's TX side. Read requests get a data response of the same burst length; write requests get a single dataless acknowledge. Used as the remote memory model and as the bring-up target for MLink links.

## Interface
- MEM_ADDR_WIDTH, 10: RAM holds 2^MEM_ADDR_WIDTH 64-bit words.
- MAX_BURST_WIDTH, 4: max burst is 2^MAX_BURST_WIDTH beats.

- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-high.
- kl_rx_addr  input  32  request byte address.
- kl_rx_data  input  64  write data beat.
- kl_rx_den  input  1  1 = write (data beats follow), 0 = read.
- kl_rx_size  input  3  log2 of transfer bytes.
- kl_rx_id  input  5  requester ID.
- kl_rx_valid  input  1  request/beat valid.
- kl_rx_ready  output  1  request/beat accepted when valid && ready.
- kl_tx_addr  output  32  response address (copy of request).
- kl_tx_data  output  64  read data beat; 0 on acks.
- kl_tx_den  output  1  1 = read data response, 0 = write ack.
- kl_tx_size  output  3  copy of request size.
- kl_tx_id  output  5  copy of request ID.
- kl_tx_valid  output  1  response/beat valid.
- kl_tx_ready  input  1  response/beat accepted when valid && ready.

## Operation
- Beat count N = 1 if size <= 3, else 2^(size-3), clamped to 2^MAX_BURST_WIDTH. Counter is MAX_BURST_WIDTH+1 bits.
- Word index W = addr[MEM_ADDR_WIDTH+2:3]; upper address bits ignored (aliasing). Beat k uses (W+k) mod 2^MEM_ADDR_WIDTH (wraps at top of RAM).
- Sub-word write (size < 3): only byte lanes addr[2:0] .. addr[2:0]+2^size-1 written, taken from the same lanes of kl_rx_data; lanes beyond 7 dropped. Writes of size >= 3 write all 8 lanes. Reads always return the full word.
- RAM: 1-cycle synchronous read, registered output; contents not reset.
- States:
  - IDLE: kl_rx_ready=1. On handshake, latch addr/size/id/den and compute N. den=1: write beat 0 this cycle; go to WR_ACK if N=1, else WR_DATA. den=0: go to RD_FETCH, beat=0.
  - WR_DATA: kl_rx_ready=1. Each handshake writes beat k; after beat N-1 go to WR_ACK. Header fields on these beats are ignored.
  - WR_ACK: kl_rx_ready=0, kl_tx_valid=1, kl_tx_den=0, kl_tx_data=0. On kl_tx_ready go to IDLE.
  - RD_FETCH: kl_rx_ready=0, kl_tx_valid=0. Issue RAM read of beat k; next cycle go to RD_SEND.
  - RD_SEND: kl_tx_valid=1, kl_tx_den=1, kl_tx_data = RAM output. On kl_tx_ready: if k = N-1 go to IDLE, else k+1 and go to RD_FETCH.
- The first TX transfer of a read carries header and beat 0; every beat presents the same addr/size/id/den.
- One outstanding request. No new request is accepted until the response completes.

## Timing
- kl_rx_ready and kl_tx_valid are decoded from the state register only. Neither depends combinationally on kl_rx_valid or kl_tx_ready.
- Once kl_tx_valid is asserted, it and all kl_tx_* stay stable until the handshake.
- Read: request accepted at cycle T, kl_tx_valid at T+2. Each further beat comes 2 cycles after the previous handshake, so throughput is 1 beat per 2 cycles with kl_tx_ready tied high.
- Write: last beat accepted at T, ack valid at T+1. Back-to-back write beats are accepted every cycle.
- Earliest next request after a response handshake at T is cycle T+1.
- Reset: while rst=1 and in the cycle after, outputs are kl_rx_ready=0, kl_tx_valid=0, and kl_tx_addr/data/den/size/id=0; state is IDLE. kl_rx_ready=1 from the cycle after rst deasserts.
- Reset mid-operation aborts the transaction. No ack or remaining beats are sent. Beats already written remain in RAM.

## Test plan
- Single write then read: write den=1, size=3, addr=0x100, data=0xDEADBEEF_01234567, id=5 -> one ack (den=0, id=5, addr=0x100) at T+1. Read of the same address -> den=1, data=0xDEADBEEF_01234567, id=5 at T+2.
- Burst: write size=5 (4 beats), addr=0x40, data 1..4 -> 4 beats accepted on consecutive cycles and one ack. Read size=5 -> 4 beats with data 1,2,3,4 and addr/size/id constant across beats.
- Sub-word: write size=1, addr=0x206, data=0xAABB_0000_0000_0000 over a word previously filled with 0 -> read of 0x200 returns 0xAABB_0000_0000_0000. Then write size=0 to 0x201 with data 0x...11.. -> only byte 1 changes.
- Wrap and backpressure: MEM_ADDR_WIDTH=10, burst size=5 at word 1022 with kl_tx_ready randomly low -> beats come from words 1022, 1023, 0, 1. Valid and data stay stable while ready is low, and no beat is lost or duplicated.
- Reset mid-burst: assert rst after 2 of 4 write beats -> kl_tx_valid stays 0 and no ack is sent. Words 0–1 of the burst hold the new data, and kl_rx_ready returns 1 the cycle after rst deasserts.
